// File: rtl/decoder_onehot_pipe_if.sv
// rtl/decoder_onehot_pipe_if.sv - handshake bundle for the registered binary-to-N decoder
interface decoder_onehot_pipe_if #(
    parameter int OUT_W = 8
);
    localparam int IN_W = $clog2(OUT_W);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;
    logic [OUT_W-1:0] hit;
    logic             hit_clr;

    modport master (
        output in_valid, in_code, in_mode, out_ready, hit_clr,
        input  in_ready, out_valid, out_data, out_err, hit
    );

    modport slave (
        input  in_valid, in_code, in_mode, out_ready, hit_clr,
        output in_ready, out_valid, out_data, out_err, hit
    );
endinterface

// File: rtl/decoder_onehot_pipe.sv
// rtl/decoder_onehot_pipe.sv - registered binary-to-N decoder, four modes, sticky hit; DECODER_ONEHOT_PIPE_ERR_EN adds out_err
module decoder_onehot_pipe #(
    parameter int OUT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    decoder_onehot_pipe_if.slave bus
);
    localparam int IN_W = $clog2(OUT_W);

    logic [IN_W-1:0]  code;
    logic             legal;
    logic             in_ready_w;
    logic             accept;
    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] therm;
    logic [OUT_W-1:0] dec;
    logic [OUT_W-1:0] hit_next;

    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic [OUT_W-1:0] hit_q;

    assign code  = bus.in_code;
    assign legal = (int'(code) < OUT_W);

    // Single output register: a slot frees up whenever the current word leaves.
    assign in_ready_w = !rst && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_w;

    always_comb begin
        onehot = '0;
        therm  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot[i] = (i == int'(code));
            therm[i]  = (i <= int'(code));
        end
        dec = '0;
        case (bus.in_mode)
            2'b00:   dec = onehot;
            2'b01:   dec = ~onehot;
            2'b10:   dec = therm;
            default: dec = ~therm;
        endcase
        if (!legal) begin
            dec = '0;
        end
    end

    // onehot is naturally all-zero for an out-of-range code, so illegal codes never mark hit.
    always_comb begin
        hit_next = bus.hit_clr ? '0 : hit_q;
        if (accept) begin
            hit_next = hit_next | onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            hit_q       <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= dec;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            hit_q <= hit_next;
        end
    end

`ifdef DECODER_ONEHOT_PIPE_ERR_EN
    logic out_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_err_q <= 1'b0;
        end else if (accept) begin
            out_err_q <= !legal;
        end
    end

    assign bus.out_err = out_err_q;
`else
    assign bus.out_err = 1'b0;
`endif

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.hit       = hit_q;
endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// tb/tb_decoder_onehot_pipe.sv - directed bench for decoder_onehot_pipe (8-wide and 6-wide instances)
module tb_decoder_onehot_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    decoder_onehot_pipe_if #(.OUT_W(8)) b8 ();
    decoder_onehot_pipe_if #(.OUT_W(6)) b6 ();

    decoder_onehot_pipe #(.OUT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    decoder_onehot_pipe #(.OUT_W(6)) dut6 (.clk(clk), .rst(rst), .bus(b6));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (b8.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", b8.out_valid); end
        total++; if (b8.out_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", b8.out_data); end
        total++; if (b8.hit !== 8'h00) begin bad++; $display("FAIL rst_hit got=%h exp=00", b8.hit); end
        total++; if (b8.out_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", b8.out_err); end
        total++; if (b8.in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", b8.in_ready); end
        rst = 1'b0;
        #1;
        total++; if (b8.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", b8.in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        b8.out_ready = 1'b1;
        b8.in_mode   = 2'b00;
        for (int c = 0; c < 8; c++) begin
            b8.in_valid = 1'b1;
            b8.in_code  = 3'(c);
            step();
            total++; if (b8.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid code=%0d got=%b exp=1", c, b8.out_valid); end
            total++; if (b8.out_data !== exp_tab[c]) begin bad++; $display("FAIL b2b_data code=%0d got=%h exp=%h", c, b8.out_data, exp_tab[c]); end
        end
        b8.in_valid = 1'b0;
        total++; if (b8.hit !== 8'hFF) begin bad++; $display("FAIL b2b_hit got=%h exp=ff", b8.hit); end
        step();
        total++; if (b8.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", b8.out_valid); end
        total++; if (b8.out_data !== 8'h80) begin bad++; $display("FAIL b2b_keep got=%h exp=80", b8.out_data); end
    endtask

    task automatic test_modes();
        logic [2:0] code_tab [7] = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd0, 3'd7, 3'd7};
        logic [1:0] mode_tab [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
        logic [7:0] exp_tab  [7] = '{8'h20, 8'hDF, 8'h3F, 8'hC0, 8'h01, 8'h00, 8'hFF};
        b8.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b8.in_valid = 1'b1;
            b8.in_code  = code_tab[i];
            b8.in_mode  = mode_tab[i];
            step();
            total++; if (b8.out_data !== exp_tab[i]) begin bad++; $display("FAIL mode code=%0d mode=%0d got=%h exp=%h", code_tab[i], mode_tab[i], b8.out_data, exp_tab[i]); end
        end
        b8.in_valid = 1'b0;
        b8.in_mode  = 2'b00;
        step();
    endtask

    task automatic test_backpressure();
        b8.out_ready = 1'b1;
        b8.in_valid  = 1'b1;
        b8.in_code   = 3'd3;
        step();
        total++; if (b8.out_data !== 8'h08) begin bad++; $display("FAIL bp_first got=%h exp=08", b8.out_data); end
        b8.out_ready = 1'b0;
        b8.in_code   = 3'd6;
        #1;
        total++; if (b8.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", b8.in_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (b8.out_data !== 8'h08 || b8.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=08/1", i, b8.out_data, b8.out_valid); end
            total++; if (b8.in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready cyc=%0d got=%b exp=0", i, b8.in_ready); end
        end
        b8.out_ready = 1'b1;
        #1;
        total++; if (b8.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", b8.in_ready); end
        step();
        b8.in_valid = 1'b0;
        total++; if (b8.out_data !== 8'h40 || b8.out_valid !== 1'b1) begin bad++; $display("FAIL bp_next got=%h/%b exp=40/1", b8.out_data, b8.out_valid); end
        step();
        total++; if (b8.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", b8.out_valid); end
    endtask

    task automatic test_hit_clr();
        b8.out_ready = 1'b1;
        b8.in_valid  = 1'b0;
        b8.hit_clr   = 1'b1;
        step();
        total++; if (b8.hit !== 8'h00) begin bad++; $display("FAIL hclr_clear got=%h exp=00", b8.hit); end
        b8.hit_clr  = 1'b0;
        b8.in_valid = 1'b1;
        b8.in_code  = 3'd1;
        step();
        b8.in_code = 3'd4;
        step();
        total++; if (b8.hit !== 8'h12) begin bad++; $display("FAIL hclr_build got=%h exp=12", b8.hit); end
        b8.hit_clr = 1'b1;
        b8.in_code = 3'd0;
        step();
        b8.hit_clr  = 1'b0;
        b8.in_valid = 1'b0;
        total++; if (b8.hit !== 8'h01) begin bad++; $display("FAIL hclr_same got=%h exp=01", b8.hit); end
        total++; if (b8.out_data !== 8'h01) begin bad++; $display("FAIL hclr_data got=%h exp=01", b8.out_data); end
        step();
    endtask

    task automatic test_illegal();
        logic exp_err;
`ifdef DECODER_ONEHOT_PIPE_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        b6.out_ready = 1'b1;
        b6.in_valid  = 1'b1;
        b6.in_code   = 3'd2;
        b6.in_mode   = 2'b00;
        step();
        total++; if (b6.out_data !== 6'h04 || b6.out_err !== 1'b0) begin bad++; $display("FAIL ill_legal got=%h/%b exp=04/0", b6.out_data, b6.out_err); end
        b6.in_code = 3'd7;
        b6.in_mode = 2'b10;
        step();
        total++; if (b6.out_data !== 6'h00) begin bad++; $display("FAIL ill_data got=%h exp=00", b6.out_data); end
        total++; if (b6.out_err !== exp_err) begin bad++; $display("FAIL ill_err got=%b exp=%b", b6.out_err, exp_err); end
        total++; if (b6.hit !== 6'h04) begin bad++; $display("FAIL ill_hit got=%h exp=04", b6.hit); end
        b6.in_code = 3'd5;
        b6.in_mode = 2'b11;
        step();
        total++; if (b6.out_data !== 6'h00 || b6.out_err !== 1'b0) begin bad++; $display("FAIL ill_top_inv got=%h/%b exp=00/0", b6.out_data, b6.out_err); end
        b6.in_code = 3'd4;
        b6.in_mode = 2'b10;
        step();
        b6.in_valid = 1'b0;
        total++; if (b6.out_data !== 6'h1F) begin bad++; $display("FAIL w6_therm got=%h exp=1f", b6.out_data); end
        total++; if (b6.hit !== 6'h34) begin bad++; $display("FAIL w6_hit got=%h exp=34", b6.hit); end
        step();
    endtask

    task automatic test_reset_mid();
        b8.out_ready = 1'b0;
        b8.in_valid  = 1'b1;
        b8.in_code   = 3'd2;
        b8.in_mode   = 2'b00;
        step();
        total++; if (b8.out_valid !== 1'b1 || b8.out_data !== 8'h04) begin bad++; $display("FAIL mid_load got=%h/%b exp=04/1", b8.out_data, b8.out_valid); end
        rst = 1'b1;
        #1;
        total++; if (b8.in_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_rst got=%b exp=0", b8.in_ready); end
        step();
        total++; if (b8.out_valid !== 1'b0 || b8.out_data !== 8'h00) begin bad++; $display("FAIL mid_drop got=%h/%b exp=00/0", b8.out_data, b8.out_valid); end
        total++; if (b8.hit !== 8'h00) begin bad++; $display("FAIL mid_hit got=%h exp=00", b8.hit); end
        total++; if (b8.in_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_hold got=%b exp=0", b8.in_ready); end
        rst = 1'b0;
        b8.in_valid = 1'b0;
        #1;
        total++; if (b8.in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_rel got=%b exp=1", b8.in_ready); end
        step();
        total++; if (b8.out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_accept got=%b exp=0", b8.out_valid); end
    endtask

    initial begin
        b8.in_valid = 1'b0; b8.in_code = '0; b8.in_mode = 2'b00; b8.out_ready = 1'b1; b8.hit_clr = 1'b0;
        b6.in_valid = 1'b0; b6.in_code = '0; b6.in_mode = 2'b00; b6.out_ready = 1'b1; b6.hit_clr = 1'b0;
        test_reset();
        test_back_to_back();
        test_modes();
        test_backpressure();
        test_hit_clr();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decoder_onehot_pipe.md
# decoder_onehot_pipe

Parametrised, registered binary-to-N decoder with valid/ready handshake on both sides, four output modes (one-hot, active-low one-hot, thermometer, inverted thermometer), and a sticky hit accumulator. It generalises the fixed 3-to-8 combinational decoder to any output width. It sits between a command/select source and downstream enable logic that needs a clean, pipelined, back-pressurable select vector.

## Interface
- `OUT_W`, default 8: number of output lines, legal range 2..256; need not be a power of two.
- `IN_W`, derived as `$clog2(OUT_W)` and not overridable: code width.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: `in_code`/`in_mode` are valid.
- `in_ready` output 1: block can accept this cycle.
- `in_code` input IN_W: binary code to decode.
- `in_mode` input 2: 00 one-hot, 01 active-low one-hot, 10 thermometer, 11 inverted thermometer.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: downstream accepts this cycle.
- `out_data` output OUT_W: decoded vector.
- `out_err` output 1: illegal code flag, qualified by `out_valid`. Constant 0 when the feature is compiled out.
- `hit` output OUT_W: sticky OR of the one-hot form of every accepted legal code.
- `hit_clr` input 1: clears `hit`.

## Operation
- Accept occurs when `in_valid && in_ready`.
- `in_ready = !rst && (!out_valid || out_ready)`. This gives full throughput with a single output register and no skid buffer.
- On accept, register the decode of (`in_code`, `in_mode`) into `out_data` and set `out_valid` to 1.
- When `out_valid && out_ready` and there is no accept, clear `out_valid` to 0. `out_data` keeps its last value.
- While `out_valid && !out_ready`, `out_data` and `out_err` are held stable. No accept is possible in this state.
- Decode for code c < OUT_W:
  - one-hot: bit c = 1, all others 0.
  - active-low one-hot: the bitwise inverse of one-hot.
  - thermometer: bits 0..c = 1 (code 0 gives 0...01).
  - inverted thermometer: bits c+1..OUT_W-1 = 1 (code OUT_W-1 gives all 0).
- Code c ≥ OUT_W (possible only when OUT_W is not a power of two) is illegal. `out_data` is all 0 for every mode and `hit` is not updated.
- `hit` update:
  - On each accept of a legal code, set bit c.
  - `hit_clr` clears all bits.
  - If `hit_clr` and an accept occur in the same cycle, `hit` is cleared and then bit c of the new code is set.

## Timing
- Latency is 1 cycle: a code accepted at edge N is visible on `out_data`/`out_valid` after edge N.
- `hit` updates on the same edge as `out_data`.
- Throughput is one code per cycle while `out_ready` is held at 1.
- Reset values (synchronous, take effect at the first edge with `rst` high):
  - `out_valid` = 0, `out_data` = 0, `out_err` = 0, `hit` = 0.
  - `in_ready` is 0 while `rst` is high.
- Reset mid-transfer drops any held output. No accept occurs in a cycle with `rst` high.
- No combinational path from `in_valid`, `in_code` or `in_mode` to any output. `in_ready` depends combinationally on `out_ready` only.

## Configuration
- `DECODER_ONEHOT_PIPE_ERR_EN`:
  - Defined: illegal codes register `out_err` = 1 alongside the all-zero `out_data`. Legal codes register `out_err` = 0.
  - Undefined: no `out_err` register; the port is tied to 0. Illegal codes still produce all-zero `out_data` and do not update `hit`.

## Test plan
- OUT_W=8, `out_ready`=1, one-hot mode, codes 0..7 back-to-back → `out_data` = 0x01, 0x02, …, 0x80 on consecutive cycles, one cycle after each accept; `hit` ends at 0xFF.
- OUT_W=8, code 5 in each mode → one-hot 0x20, active-low 0xDF, thermometer 0x3F, inverted thermometer 0xC0.
- Backpressure: accept code 3, hold `out_ready`=0 for 4 cycles while `in_valid`=1 with code 6 → `in_ready`=0, `out_data` stays 0x08. Release → 0x08 transfers, then 0x40 appears on the next cycle.
- OUT_W=6 with ERR_EN defined, code 7 → `out_data`=0x00, `out_err`=1, `hit` unchanged. With ERR_EN undefined → `out_err`=0.
- `hit` = 0x12, then `hit_clr` in the same cycle as accepting code 0 → `hit` = 0x01.
- Assert `rst` while `out_valid`=1 and `out_ready`=0 → next edge gives `out_valid`=0, `out_data`=0, `hit`=0; `in_ready`=0 during reset and 1 in the cycle after release.
